// File: rtl/serial_to_parallel_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel_align_pkg
// Description : Shared state encoding and default COM character for the
//               receive-side byte aligner.
// Revision    : 1.0
// ============================================================================
package serial_to_parallel_align_pkg;

    localparam logic [7:0] COM_CHAR_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage : serial_to_parallel_align_pkg
`default_nettype wire

// File: rtl/serial_to_parallel_align_sp_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel_align_sp_shift_reg
// Description : MSB-first serial shift register; nxt_o is the window that
//               includes the bit currently on data_in.
// Revision    : 1.0
// ============================================================================
module serial_to_parallel_align_sp_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [DATA_W-1:0] sr_o,
    output logic [DATA_W-1:0] nxt_o
);

    logic [DATA_W-1:0] sr_q;

    assign nxt_o = {sr_q[DATA_W-2:0], data_in};
    assign sr_o  = sr_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sr_q <= '0;
        end else begin
            sr_q <= nxt_o;
        end
    end

endmodule : serial_to_parallel_align_sp_shift_reg
`default_nettype wire

// File: rtl/serial_to_parallel_align.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel_align
// Description : Deserializer that aligns on the COM character and, once
//               BC_REQ aligned COMs are seen, emits each byte with a valid flag.
// Revision    : 1.0
// ============================================================================
module serial_to_parallel_align
    import serial_to_parallel_align_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] COM_CHAR = DATA_W'(COM_CHAR_DEFAULT),
    parameter int                BC_REQ   = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_strobe,
    output logic              active
);

    localparam int                CNT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  c_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        c_BC_REQ = 4'(BC_REQ);

    logic [DATA_W-1:0] w_sr_unused;
    logic [DATA_W-1:0] w_nxt;
    logic              w_is_com;
    logic              w_last;
    logic [CNT_W-1:0]  w_bit_inc;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        bc_cnt_q, bc_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;
    logic              active_q, active_d;

    serial_to_parallel_align_sp_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk     (clk),
        .reset_L (reset_L),
        .data_in (data_in),
        .sr_o    (w_sr_unused),
        .nxt_o   (w_nxt)
    );

    assign w_is_com  = (w_nxt == COM_CHAR);
    assign w_last    = (bit_cnt_q == c_LAST);
    assign w_bit_inc = w_last ? '0 : bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (w_is_com) begin
                    bit_cnt_d = '0;
                    bc_cnt_d  = 4'd1;
                    state_d   = (c_BC_REQ == 4'd1) ? ST_ACTIVE : ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                bit_cnt_d = w_bit_inc;
                if (w_last) begin
                    if (w_is_com) begin
                        if (bc_cnt_q + 4'd1 >= c_BC_REQ) begin
                            bc_cnt_d = c_BC_REQ;
                            state_d  = ST_ACTIVE;
                        end else begin
                            bc_cnt_d = bc_cnt_q + 4'd1;
                        end
                    end else begin
                        // Resume sliding search from the next bit, not this one.
                        state_d  = ST_SEARCH;
                        bc_cnt_d = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                bit_cnt_d = w_bit_inc;
                if (w_last) begin
                    data_d   = w_nxt;
                    valid_d  = !w_is_com;
                    strobe_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                bit_cnt_d = '0;
                bc_cnt_d  = '0;
            end
        endcase
    end

    assign active_d = (state_d == ST_ACTIVE);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_SEARCH;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule : serial_to_parallel_align
`default_nettype wire

// File: tb/tb_serial_to_parallel_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_to_parallel_align
// Description : Directed self-checking bench for serial_to_parallel_align.
// Revision    : 1.0
// ============================================================================
module tb_serial_to_parallel_align;

    logic       clk;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_cmp;
    int n_bad;
    int hold_viol;
    int dbl_strobe;
    logic [7:0] prev_data;
    logic       prev_valid;
    logic       prev_strobe;
    time        last_t;

    serial_to_parallel_align u_dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    // Sends b while active and checks the strobe lands on its last bit only.
    task automatic byte_check(input string tag, input logic [7:0] b, input logic v,
                              input logic chk_period);
        send_bits(b, 7);
        chk({tag, "_nostrobe"}, byte_strobe, 1'b0);
        send_bit(b[0]);
        chk({tag, "_strobe"}, byte_strobe, 1'b1);
        chk({tag, "_data"}, data_out, b);
        chk({tag, "_valid"}, valid_out, v);
        if (chk_period) chk({tag, "_period"}, 32'($time - last_t), 32'd80);
        last_t = $time;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        chk("rst_active", active, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_strobe", byte_strobe, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_L) begin
            if (byte_strobe && prev_strobe) dbl_strobe++;
            if (!byte_strobe && (data_out !== prev_data || valid_out !== prev_valid))
                hold_viol++;
        end
        prev_data   = data_out;
        prev_valid  = valid_out;
        prev_strobe = byte_strobe;
    end

    initial begin
        n_cmp = 0; n_bad = 0; hold_viol = 0; dbl_strobe = 0;
        prev_data = '0; prev_valid = 1'b0; prev_strobe = 1'b0; last_t = 0;
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_active", active, 1'b0);
        chk("init_data", data_out, 8'h00);
        chk("init_valid", valid_out, 1'b0);
        chk("init_strobe", byte_strobe, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;

        // Alignment after a 3-bit offset
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        repeat (3) send_byte(8'hBC);
        chk("al_pre3", active, 1'b0);
        send_bits(8'hBC, 7);
        chk("al_pre4", active, 1'b0);
        send_bit(1'b0);
        chk("al_active", active, 1'b1);
        chk("al_nostrobe", byte_strobe, 1'b0);
        chk("al_data0", data_out, 8'h00);
        byte_check("al_5A", 8'h5A, 1'b1, 1'b0);
        byte_check("al_C3", 8'hC3, 1'b1, 1'b1);

        // Idle COM while active
        byte_check("idle_11", 8'h11, 1'b1, 1'b1);
        byte_check("idle_BC", 8'hBC, 1'b0, 1'b1);
        byte_check("idle_33", 8'h33, 1'b1, 1'b1);

        // Reset in the middle of a byte
        send_bits(8'h77, 3);
        pulse_reset();
        send_byte(8'h5A);
        send_byte(8'h5A);
        chk("rst_search_active", active, 1'b0);
        chk("rst_search_strobe", byte_strobe, 1'b0);

        // Broken COM run
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h17);
        chk("brk_after17", active, 1'b0);
        repeat (3) send_byte(8'hBC);
        chk("brk_pre4", active, 1'b0);
        send_byte(8'hBC);
        chk("brk_active", active, 1'b1);
        chk("brk_nostrobe", byte_strobe, 1'b0);
        byte_check("brk_22", 8'h22, 1'b1, 1'b0);

        // False COM across a byte boundary
        pulse_reset();
        send_byte(8'h5E);
        send_byte(8'h00);
        chk("fc_after00", active, 1'b0);
        repeat (3) send_byte(8'hBC);
        chk("fc_pre4", active, 1'b0);
        send_byte(8'hBC);
        chk("fc_active", active, 1'b1);
        byte_check("fc_A5", 8'hA5, 1'b1, 1'b0);
        byte_check("fc_3C", 8'h3C, 1'b1, 1'b1);

        repeat (3) send_bit(1'b1);
        chk("hold_violations", 32'(hold_viol), 32'd0);
        chk("double_strobes", 32'(dbl_strobe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_to_parallel_align
`default_nettype wire
